mips_encode_issuer: RTL and testbench

Encoder counterpart to `mips_decode`: accepts ALU micro-op requests (ALU op, register fields, optional 16-bit immediate) over a valid/ready handshake and encodes each one into a 32-bit MIPS R-type or I-type instruction word. Encoded words are queued in a small FIFO and issued downstream over a second valid/ready handshake. Requests with no legal encoding are dropped, flagged and counted. The block feeds instruction streams into decoder and datapath benches and into the Lab4 instruction memory loader.

---
 rtl/mips_encode_issuer.sv | 105 ++++++++++
 tb/tb_mips_encode_issuer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_encode_issuer.sv
// Encodes ALU micro-op requests into MIPS R/I-type words and issues them through a small FIFO.
// Requests with no legal encoding are handshaken, dropped, pulsed on err and counted.
module mips_encode_issuer #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_alu_op,
   input  logic                     in_imm_sel,
   input  logic [4:0]               in_rs,
   input  logic [4:0]               in_rt,
   input  logic [4:0]               in_rd,
   input  logic [15:0]              in_imm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err,
   output logic [7:0]               err_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;
   localparam logic [2:0] ALU_XOR = 3'd7;

   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_XORI = 6'h0e;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          legal;
   logic [5:0]    funct;
   logic [5:0]    opcode;
   logic [31:0]   word;
   logic          accept;
   logic          push;
   logic          pop;
   logic          bad;

   always_comb begin
      legal  = 1'b1;
      funct  = 6'h00;
      opcode = 6'h00;
      case (in_alu_op)
         ALU_ADD: begin funct = 6'h20; opcode = OP_ADDI; end
         ALU_SUB: begin funct = 6'h22; legal = ~in_imm_sel; end
         ALU_AND: begin funct = 6'h24; opcode = OP_ANDI; end
         ALU_OR:  begin funct = 6'h25; opcode = OP_ORI;  end
         ALU_NOR: begin funct = 6'h27; legal = ~in_imm_sel; end
         ALU_XOR: begin funct = 6'h26; opcode = OP_XORI; end
         default: legal = 1'b0;
      endcase
      // I-type writes rt; rd is unused in that form
      if (in_imm_sel)
         word = {opcode, in_rs, in_rt, in_imm};
      else
         word = {6'h00, in_rs, in_rt, in_rd, 5'h00, funct};
   end

   // Ready depends on occupancy alone, so a same-cycle pop never admits an extra push
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign bad       = accept & ~legal;
   assign pop       = out_valid & out_ready;
   assign out_inst  = out_valid ? mem[rd_ptr] : 32'h0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err       <= 1'b0;
         err_count <= 8'h00;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else begin
         err <= bad;
         if (bad && err_count != 8'hff) err_count <= err_count + 8'd1;
         if (push) begin
            mem[wr_ptr] <= word;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_encode_issuer.sv
// Scoreboard bench for mips_encode_issuer: a predictor queues expected words from a spec-level
// encoder model, a monitor pops and compares whenever the DUT issues a word.
module tb_mips_encode_issuer;

   localparam int DEPTH = 4;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_alu_op;
   logic        in_imm_sel;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [2:0]  count;
   logic        err;
   logic [7:0]  err_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   int          mdl_cnt  = 0;
   int          mdl_errc = 0;
   bit          err_pend = 0;

   mips_encode_issuer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_imm_sel(in_imm_sel),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .count(count), .err(err), .err_count(err_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // reference model: tables straight from the instruction formats
   function automatic bit ref_legal(int op, bit sel);
      if (op < 2) return 0;
      if (sel && (op == 3 || op == 6)) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] ref_enc(int op, bit sel, int rs, int rt, int rd, int imm);
      int functs [8] = '{0, 0, 32, 34, 36, 37, 39, 38};
      int opcs   [8] = '{0, 0, 8, 0, 12, 13, 0, 14};
      longint w;
      if (sel) w = opcs[op] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      else     w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + functs[op];
      return w[31:0];
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, got, exp, $time);
      end
   endtask

   // predictor: checks model state, then advances it with this cycle's handshakes
   always @(negedge clock) begin
      bit acc, lg, pp;
      if (reset) begin
         chk("count", 32'(count), 32'(mdl_cnt));
         chk("in_ready", 32'(in_ready), 32'(mdl_cnt != DEPTH));
         chk("out_valid", 32'(out_valid), 32'(mdl_cnt != 0));
         if (mdl_cnt == 0) chk("out_inst_empty", out_inst, 32'h0);
         chk("err", 32'(err), 32'(err_pend));
         chk("err_count", 32'(err_count), 32'(mdl_errc));
         acc = in_valid && (mdl_cnt != DEPTH);
         lg  = ref_legal(int'(in_alu_op), in_imm_sel);
         pp  = out_ready && (mdl_cnt != 0);
         err_pend = acc && !lg;
         if (err_pend && mdl_errc < 255) mdl_errc++;
         if (acc && lg)
            exp_q.push_back(ref_enc(int'(in_alu_op), in_imm_sel, int'(in_rs), int'(in_rt),
                                    int'(in_rd), int'(in_imm)));
         mdl_cnt = mdl_cnt + int'(acc && lg) - int'(pp);
      end
   end

   // monitor: compares every issued word against the scoreboard head
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_unexpected actual=%h required=none", out_inst);
         end else begin
            chk("issue_order", out_inst, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(int op, bit sel, int rs, int rt, int rd, int imm);
      in_alu_op  = 3'(op);
      in_imm_sel = sel;
      in_rs      = 5'(rs);
      in_rt      = 5'(rt);
      in_rd      = 5'(rd);
      in_imm     = 16'(imm);
      in_valid   = 1'b1;
   endtask

   task automatic set_rand_legal();
      int op;
      bit sel;
      do begin
         op  = int'($urandom_range(2, 7));
         sel = 1'($urandom);
      end while (!ref_legal(op, sel));
      set_req(op, sel, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
   endtask

   // returns one tick after the accepting edge, with in_valid dropped
   task automatic wait_accept(int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clock);
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            done = 1;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         in_valid = 1'b0;
         $display("FAIL accept_timeout actual=no_accept required=accept_within_%0d", budget);
      end
   endtask

   task automatic drain(int budget);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < budget && count != 0; i++) tick();
      tick();
      chk("drain_empty", 32'(count), 32'h0);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu_op = 3'd0; in_imm_sel = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0;
      #3;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_err_count", 32'(err_count), 32'h0);
      #9 reset = 1'b1;
      tick();

      // directed encodings, consumer always ready
      out_ready = 1'b1;
      set_req(2, 0, 1, 2, 3, 0); wait_accept(5);
      chk("add_r_word", out_inst, 32'h00221820);
      chk("add_r_count1", 32'(count), 32'h1);
      tick();
      chk("add_r_count0", 32'(count), 32'h0);
      set_req(2, 1, 4, 5, 7, 16'h1234); wait_accept(5);
      chk("addi_word", out_inst, 32'h20851234);
      tick();
      set_req(7, 1, 0, 9, 0, 16'hffff); wait_accept(5);
      chk("xori_word", out_inst, 32'h3809ffff);
      tick();
      set_req(6, 0, 31, 31, 31, 0); wait_accept(5);
      chk("nor_r_word", out_inst, 32'h03fff827);
      tick();

      // backpressure: four fill, fifth is held until the consumer resumes
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin set_rand_legal(); wait_accept(5); end
      chk("full_in_ready", 32'(in_ready), 32'h0);
      set_rand_legal();
      repeat (3) tick();
      chk("full_hold_count", 32'(count), 32'h4);
      out_ready = 1'b1;
      wait_accept(10);
      drain(20);

      // illegal requests: dropped, pulsed, counted
      set_req(3, 1, 1, 2, 3, 5); wait_accept(5);
      chk("err_sub_i", 32'(err), 32'h1);
      set_req(0, 0, 1, 2, 3, 5); wait_accept(5);
      chk("err_op0", 32'(err), 32'h1);
      chk("err_count2", 32'(err_count), 32'h2);
      chk("err_count_fifo", 32'(count), 32'h0);
      tick();
      chk("err_low", 32'(err), 32'h0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 0) set_req(int'($urandom_range(0, 1)), 1'($urandom), 1, 2, 3, 4);
         else set_req(($urandom_range(0, 1) == 0) ? 3 : 6, 1'b1, 1, 2, 3, 4);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("err_saturate", 32'(err_count), 32'd255);

      // simultaneous push/pop at count 2, wrapping the pointers
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin set_rand_legal(); wait_accept(5); end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_rand_legal();
         tick();
         chk("pushpop_count2", 32'(count), 32'h2);
      end
      drain(20);

      // push/pop at full: the push is blocked by occupancy
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin set_rand_legal(); wait_accept(5); end
      out_ready = 1'b1;
      set_rand_legal();
      tick();
      in_valid = 1'b0;
      chk("full_pushpop_count3", 32'(count), 32'h3);
      drain(20);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin set_rand_legal(); wait_accept(5); end
      chk("pre_reset_count", 32'(count), 32'h3);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'h0);
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_inst", out_inst, 32'h0);
      exp_q.delete();
      mdl_cnt = 0; mdl_errc = 0; err_pend = 0;
      @(negedge clock); #2;
      reset = 1'b1;
      tick();
      out_ready = 1'b1;
      set_req(4, 1, 3, 6, 0, 16'h00f0); wait_accept(5);
      chk("post_rst_word", out_inst, ref_enc(4, 1, 3, 6, 0, 16'h00f0));
      tick();

      // randomized traffic, all checking via predictor and monitor
      for (int i = 0; i < 400; i++) begin
         set_req(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 65535)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain(20);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
